alu_rr_arbiter: RTL and testbench

Shares one combinational ALU (N-bit, 4-bit ctrl, zero/negative/overflow/carry flags) among NREQ requesters. Each requester presents one operation with a valid/ready handshake. A round-robin scheduler grants one requester, registers its operands, drives the ALU for one cycle and captures the result and flags. It then returns a tagged response on a single valid/ready response channel. The block sits between the issue logic and the shared alu instance.

---
 rtl/alu_rr_arbiter_if.sv | 63 ++++++
 rtl/alu_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_arbiter_if.sv
//=============================================================================
// Module      : alu_rr_arbiter_if
// Description : Bundle of every bus between the ALU arbiter, its requesters,
//               the shared ALU and the response consumer.
//                 req_*    : per-requester operation handshake (packed)
//                 alu_*    : operands out to, result and flags in from the ALU
//                 rsp_*    : tagged response handshake
//                 busy     : arbiter is not idle
//               slave  = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

interface alu_rr_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*4-1:0] req_ctrl;

    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [3:0]        alu_ctrl;
    logic [N-1:0]      alu_result;
    logic              alu_zero;
    logic              alu_negative;
    logic              alu_overflow;
    logic              alu_carry;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic [3:0]        rsp_flags;

    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl,
        input  alu_result, alu_zero, alu_negative, alu_overflow, alu_carry,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_ctrl,
        output alu_result, alu_zero, alu_negative, alu_overflow, alu_carry,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
//=============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin scheduler sharing one combinational ALU among
//               NREQ requesters. A granted operation is registered, presented
//               to the ALU for one cycle, and its result/flags are returned
//               as a tagged response (IDLE -> EXEC -> RESP).
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - alu_rr_arbiter_if.slave (requests, ALU, response, busy)
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module alu_rr_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_rr_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_last_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic [N-1:0]    r_op_a;
    logic [N-1:0]    r_op_b;
    logic [3:0]      r_op_ctrl;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [N-1:0]    r_rsp_result;
    logic [3:0]      r_rsp_flags;
    logic            r_busy;

    logic            w_found;
    logic [IDW-1:0]  w_gnt;
    logic [NREQ-1:0] w_ready;

    // Search last_gnt+1, last_gnt+2, ... (wrapping) for the first valid
    // requester; the most recently served requester is checked last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && bus.req_valid[IDW'((int'(r_last_gnt) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_gnt   = IDW'((int'(r_last_gnt) + k) % NREQ);
            end
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held,
    // even though the FSM already sits in IDLE.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= IDW'(NREQ - 1);
            r_gnt_id     <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a     <= bus.req_a[int'(w_gnt)*N +: N];
                        r_op_b     <= bus.req_b[int'(w_gnt)*N +: N];
                        r_op_ctrl  <= bus.req_ctrl[int'(w_gnt)*4 +: 4];
                        r_gnt_id   <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_busy     <= 1'b1;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result <= bus.alu_result;
                    r_rsp_flags  <= {bus.alu_zero, bus.alu_negative,
                                     bus.alu_overflow, bus.alu_carry};
                    r_rsp_id     <= r_gnt_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    // No bypass to a new grant: IDLE must be re-entered first.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.alu_a      = r_op_a;
    assign bus.alu_b      = r_op_b;
    assign bus.alu_ctrl   = r_op_ctrl;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
//=============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Directed self-checking bench for alu_rr_arbiter. A small
//               combinational ALU (add/sub/and/or/xor, everything else gives
//               result 0) stands in for the shared ALU.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_alu_rr_arbiter;

    localparam int C_N    = 32;
    localparam int C_NREQ = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    alu_rr_arbiter_if #(.N(C_N), .NREQ(C_NREQ)) bus ();

    alu_rr_arbiter #(.N(C_N), .NREQ(C_NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU
    logic [32:0] m_wide;
    logic        m_ovf;
    always_comb begin
        m_wide = 33'd0;
        m_ovf  = 1'b0;
        case (bus.alu_ctrl)
            4'd0: begin
                m_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_ovf  = (bus.alu_a[31] == bus.alu_b[31]) && (m_wide[31] != bus.alu_a[31]);
            end
            4'd1: begin
                m_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                m_ovf  = (bus.alu_a[31] != bus.alu_b[31]) && (m_wide[31] != bus.alu_a[31]);
            end
            4'd2:    m_wide = {1'b0, bus.alu_a & bus.alu_b};
            4'd3:    m_wide = {1'b0, bus.alu_a | bus.alu_b};
            4'd4:    m_wide = {1'b0, bus.alu_a ^ bus.alu_b};
            default: m_wide = 33'd0;
        endcase
        bus.alu_result   = m_wide[31:0];
        bus.alu_carry    = m_wide[32];
        bus.alu_overflow = m_ovf;
        bus.alu_zero     = (m_wide[31:0] == 32'd0);
        bus.alu_negative = m_wide[31];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*32 +: 32]  = a;
        bus.req_b[i*32 +: 32]  = b;
        bus.req_ctrl[i*4 +: 4] = c;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = {4{32'h1234_5678}};
        bus.req_b     = {4{32'h0000_0001}};
        bus.req_ctrl  = {4{4'h1}};
        #12;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); else passed++;
        checks++; if (bus.rsp_result !== 32'd0) $display("FAIL reset_rsp_result: got %h expected 0", bus.rsp_result); else passed++;
        checks++; if (bus.rsp_flags !== 4'd0) $display("FAIL reset_rsp_flags: got %b expected 0000", bus.rsp_flags); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); else passed++;
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 68'd0) $display("FAIL reset_alu_ops: got %h/%h/%h expected 0/0/0", bus.alu_a, bus.alu_b, bus.alu_ctrl); else passed++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL idle_no_req_ready: got %b expected 0000", bus.req_ready); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_single_add();
        bus.rsp_ready = 1'b1;
        set_req(1, 32'h10, 32'h20, 4'b0000);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", bus.req_ready); else passed++;
        step();
        bus.req_valid[1] = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) $display("FAIL single_ready_pulse: got %b expected 0000", bus.req_ready); else passed++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_exec: got %b expected 1", bus.busy); else passed++;
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {32'h10, 32'h20, 4'h0}) $display("FAIL single_alu_ops: got %h/%h/%h expected 10/20/0", bus.alu_a, bus.alu_b, bus.alu_ctrl); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_early: got %b expected 0", bus.rsp_valid); else passed++;
        step();
        checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_id !== 2'd1) $display("FAIL single_rsp_id: got %0d expected 1", bus.rsp_id); else passed++;
        checks++; if (bus.rsp_result !== 32'h30) $display("FAIL single_rsp_result: got %h expected 30", bus.rsp_result); else passed++;
        checks++; if (bus.rsp_flags !== 4'b0000) $display("FAIL single_rsp_flags: got %b expected 0000", bus.rsp_flags); else passed++;
        step();
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_drop: got %b expected 0", bus.rsp_valid); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_flags();
        set_req(0, 32'h8000_0000, 32'h8000_0000, 4'b0000);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("FAIL flags_ready: got %b expected 0001", bus.req_ready); else passed++;
        step();
        bus.req_valid[0] = 1'b0;
        step();
        checks++; if (bus.rsp_result !== 32'd0) $display("FAIL flags_add_result: got %h expected 0", bus.rsp_result); else passed++;
        checks++; if (bus.rsp_flags !== 4'b1011) $display("FAIL flags_add_flags: got %b expected 1011", bus.rsp_flags); else passed++;
        checks++; if (bus.rsp_id !== 2'd0) $display("FAIL flags_add_id: got %0d expected 0", bus.rsp_id); else passed++;
        step();
        // Illegal opcode passes through untouched; the ALU resolves it.
        set_req(2, 32'h7, 32'h9, 4'hF);
        step();
        bus.req_valid[2] = 1'b0;
        #1;
        checks++; if (bus.alu_ctrl !== 4'hF) $display("FAIL illegal_ctrl_pass: got %h expected f", bus.alu_ctrl); else passed++;
        step();
        checks++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {2'd2, 32'd0, 4'b1000}) $display("FAIL illegal_rsp: got id %0d res %h flg %b expected id 2 res 0 flg 1000", bus.rsp_id, bus.rsp_result, bus.rsp_flags); else passed++;
        step();
    endtask

    task automatic test_all_four();
        logic [31:0] exp_res [4];
        logic [3:0]  exp_flg [4];
        logic [3:0]  er;
        logic [3:0]  granted;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        bus.rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd3, 4'd0);                 exp_res[0] = 32'd8;          exp_flg[0] = 4'b0000;
        set_req(1, 32'd2, 32'd3, 4'd1);                 exp_res[1] = 32'hFFFF_FFFF;  exp_flg[1] = 4'b0101;
        set_req(2, 32'h0000_FF00, 32'h0000_0F0F, 4'd2); exp_res[2] = 32'h0000_0F00;  exp_flg[2] = 4'b0000;
        set_req(3, 32'd7, 32'd9, 4'hF);                 exp_res[3] = 32'd0;          exp_flg[3] = 4'b1000;
        for (int c = 0; c < 12; c++) begin
            #1;
            er = 4'b0000;
            if (c % 3 == 0) er[c/3] = 1'b1;
            checks++; if (bus.req_ready !== er) $display("FAIL four_ready c%0d: got %b expected %b", c, bus.req_ready, er); else passed++;
            if (c % 3 == 2) begin
                checks++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'(c/3)}) $display("FAIL four_rsp c%0d: got valid %b id %0d expected valid 1 id %0d", c, bus.rsp_valid, bus.rsp_id, c/3); else passed++;
                checks++; if ({bus.rsp_result, bus.rsp_flags} !== {exp_res[c/3], exp_flg[c/3]}) $display("FAIL four_data c%0d: got %h/%b expected %h/%b", c, bus.rsp_result, bus.rsp_flags, exp_res[c/3], exp_flg[c/3]); else passed++;
            end else begin
                checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL four_rsp_idle c%0d: got %b expected 0", c, bus.rsp_valid); else passed++;
            end
            granted = bus.req_ready;
            step();
            bus.req_valid = bus.req_valid & ~granted;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] er;
        set_req(0, 32'd1, 32'd1, 4'd0);
        set_req(2, 32'd2, 32'd2, 4'd0);
        for (int c = 0; c < 12; c++) begin
            #1;
            er = 4'b0000;
            if (c % 3 == 0) er = ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0100;
            checks++; if (bus.req_ready !== er) $display("FAIL fair_ready c%0d: got %b expected %b", c, bus.req_ready, er); else passed++;
            if (c % 3 == 2) begin
                checks++; if (bus.rsp_id !== (((c / 3) % 2 == 0) ? 2'd0 : 2'd2)) $display("FAIL fair_rsp_id c%0d: got %0d", c, bus.rsp_id); else passed++;
            end
            step();
        end
        bus.req_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        set_req(3, 32'd100, 32'd1, 4'd1);
        set_req(1, 32'd4, 32'd4, 4'd4);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_first_ready: got %b expected 1000", bus.req_ready); else passed++;
        step();
        bus.req_valid[3] = 1'b0;
        step();
        for (int c = 2; c <= 7; c++) begin
            #1;
            checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {1'b1, 2'd3, 32'h63, 4'b0000}) $display("FAIL bp_hold c%0d: got v%b id %0d %h %b expected v1 id 3 63 0000", c, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags); else passed++;
            checks++; if ({bus.req_ready, bus.busy} !== {4'b0000, 1'b1}) $display("FAIL bp_blocked c%0d: got ready %b busy %b expected 0000 1", c, bus.req_ready, bus.busy); else passed++;
            if (c == 7) bus.rsp_ready = 1'b1;
            step();
        end
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_rsp_drop: got %b expected 0", bus.rsp_valid); else passed++;
        checks++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b expected 0010", bus.req_ready); else passed++;
        step();
        bus.req_valid[1] = 1'b0;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== {1'b1, 2'd1, 32'd0, 4'b1000}) $display("FAIL bp_second_rsp: got v%b id %0d %h %b expected v1 id 1 0 1000", bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags); else passed++;
        step();
    endtask

    task automatic test_reset_mid_exec();
        set_req(0, 32'd11, 32'd0, 4'd0);
        set_req(2, 32'd22, 32'd0, 4'd0);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rst_pre_grant: got %b expected 0100", bus.req_ready); else passed++;
        step();
        bus.req_valid[2] = 1'b0;
        set_req(3, 32'd33, 32'd0, 4'd0);
        #1;
        checks++; if ({bus.busy, bus.alu_a} !== {1'b1, 32'd22}) $display("FAIL rst_in_exec: got busy %b a %h expected 1 16", bus.busy, bus.alu_a); else passed++;
        #2 rst_n = 1'b0;
        #2;
        checks++; if ({bus.rsp_valid, bus.busy, bus.req_ready} !== {1'b0, 1'b0, 4'b0000}) $display("FAIL rst_async: got v%b busy %b ready %b expected 0 0 0000", bus.rsp_valid, bus.busy, bus.req_ready); else passed++;
        checks++; if (bus.alu_a !== 32'd0) $display("FAIL rst_async_ops: got %h expected 0", bus.alu_a); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_ptr_cleared: got %b expected 0001", bus.req_ready); else passed++;
        step();
        bus.req_valid = 4'b0000;
        #1;
        checks++; if ({bus.rsp_valid, bus.busy, bus.alu_a} !== {1'b0, 1'b1, 32'd11}) $display("FAIL rst_post_grant: got v%b busy %b a %h expected 0 1 b", bus.rsp_valid, bus.busy, bus.alu_a); else passed++;
        step();
        checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 2'd0, 32'd11}) $display("FAIL rst_post_rsp: got v%b id %0d %h expected 1 0 b", bus.rsp_valid, bus.rsp_id, bus.rsp_result); else passed++;
        step();
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_flags();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
